// File: rtl/bcd_converter_seq.sv
// rtl/bcd_converter_seq.sv - iterative shift-add-3 binary-to-BCD converter, one bit per clock
// Optional leading-zero blanking mask enabled by macro BCD_LZB_EN.
module bcd_converter_seq #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10,
  parameter int SIGNED = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      binary,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  negative,
  output logic                  overflow,
  output logic [DIGITS-1:0]     blank
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                state;
  logic [WIDTH-1:0]      shift_reg;
  logic [4*DIGITS-1:0]   acc;
  logic [CW-1:0]         cnt;
  logic                  sign_flag;
  logic                  ovf_sticky;

  logic [4*DIGITS-1:0]   adj;
  logic [WIDTH-1:0]      mag;
  logic                  mag_neg;

  always_comb begin
    mag_neg = (SIGNED != 0) && binary[WIDTH-1];
    mag     = mag_neg ? (~binary + WIDTH'(1)) : binary;
  end

  // Add-3 correction on every digit before the shift so each doubles cleanly into the next.
  always_comb begin
    adj = acc;
    for (int k = 0; k < DIGITS; k++) begin
      if (acc[4*k +: 4] >= 4'd5) adj[4*k +: 4] = acc[4*k +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shift_reg  <= '0;
      acc        <= '0;
      cnt        <= '0;
      sign_flag  <= 1'b0;
      ovf_sticky <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      bcd        <= '0;
      negative   <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shift_reg  <= mag;
            sign_flag  <= mag_neg;
            acc        <= '0;
            ovf_sticky <= 1'b0;
            cnt        <= CW'(WIDTH - 1);
            busy       <= 1'b1;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          shift_reg  <= {shift_reg[WIDTH-2:0], 1'b0};
          acc        <= {adj[4*DIGITS-2:0], shift_reg[WIDTH-1]};
          ovf_sticky <= ovf_sticky | adj[4*DIGITS-1];
          cnt        <= cnt - CW'(1);
          if (cnt == '0) begin
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          bcd      <= acc;
          negative <= sign_flag;
          overflow <= ovf_sticky;
          done     <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BCD_LZB_EN
  logic [DIGITS-1:0] lzb;
  logic [DIGITS-1:0] blank_r;
  logic              run;

  // Walk from the top digit down; a digit blanks only while everything above it is zero.
  always_comb begin
    lzb = '0;
    run = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      run    = run & (acc[4*k +: 4] == 4'd0);
      lzb[k] = run;
    end
    lzb[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_r <= '0;
    end else if (state == DONE) begin
      blank_r <= ovf_sticky ? '0 : lzb;
    end
  end

  assign blank = blank_r;
`else
  assign blank = '0;
`endif

endmodule

// File: doc/bcd_converter_seq.md
Name: bcd_converter_seq

Overview:
Sequential, parametrised binary-to-BCD converter using iterative shift-add-3 (double dabble), one input bit per clock.
Successor to the combinational converter. Adds configurable width and digit count, a signed/unsigned mode, a start/busy/done handshake, and overflow detection.
Sits between the datapath result register and the seven-segment display driver.
Trades latency for area: one adjust/shift stage instead of WIDTH unrolled stages.

Parameters:
WIDTH, 32, input binary width in bits (>= 2)
DIGITS, 10, number of BCD output digits (>= 1)
SIGNED, 1, 1 = input is two's complement and magnitude is converted; 0 = input is unsigned

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  conversion request, sampled in IDLE only
binary  input  WIDTH  value to convert, sampled on the accepted start cycle
busy  output  1  high while a conversion is in progress
done  output  1  single-cycle pulse when results update
bcd  output  4*DIGITS  result digits; bcd[3:0] = units, bcd[4*DIGITS-1 -: 4] = most significant digit
negative  output  1  1 = converted input was negative (SIGNED=1 only; always 0 when SIGNED=0)
overflow  output  1  1 = magnitude exceeds 10^DIGITS-1; bcd is then invalid
blank  output  DIGITS  leading-zero mask (see Optional Feature)

Behaviour:
- Reset: asynchronous assertion (rst_n=0) forces
  - state=IDLE
  - busy=0, done=0
  - bcd=0, negative=0, overflow=0, blank=0
  - all internal shift/count registers = 0
- Reset mid-conversion aborts the conversion. No done pulse occurs; outputs read 0 after release.
- State IDLE:
  - start=1 captures the magnitude of binary into a WIDTH-bit shift register, clears the digit accumulator and the sticky overflow flag, and sets bit counter = WIDTH-1.
  - Goes to SHIFT; busy=1 from the next cycle.
- Magnitude rule:
  - If SIGNED=1 and binary[WIDTH-1]=1: magnitude = ~binary+1 (WIDTH bits), and the internal sign flag is set.
  - The most-negative value (e.g. 32'h80000000) gives magnitude 2^(WIDTH-1), which is representable unsigned; no special case.
  - SIGNED=0: magnitude = binary, sign flag = 0.
- State SHIFT (exactly WIDTH cycles), each cycle:
  - Every digit >= 5 gets +3 (4-bit add).
  - The accumulator {digits, magnitude} then shifts left one bit.
  - The bit leaving the top digit's MSB sets sticky overflow.
  - Counter decrements. On counter=0, go to DONE.
- State DONE (one cycle):
  - bcd, negative, overflow and blank load from internal registers; done=1, busy=0.
  - Next state IDLE.
- Latency: start accepted on edge N, done=1 in the cycle after edge N+WIDTH+1, outputs valid from that same edge.
- Throughput: one conversion per WIDTH+2 cycles. start is ignored while busy or in DONE (no queueing).
- Outputs hold their last value between conversions. binary may change freely after the start cycle.
- Overflow is only possible when DIGITS < ceil(WIDTH*log10(2)).
  - With overflow=1, bcd holds the low DIGITS digits of a wrapped result and must be treated as invalid.
  - negative still reflects the input sign.
- All arithmetic is unsigned 4-bit per digit. No digit exceeds 9 after the final shift when overflow=0.

Optional Feature:
Macro BCD_LZB_EN.
- Defined: blank[k]=1 when digit k and all higher digits are zero.
  - blank[0] is always 0, so a value of 0 displays "0".
  - blank is computed in the DONE cycle and registered with bcd.
  - With overflow=1, blank is forced to all zeros.
- Not defined: the blank port stays present, tied to all zeros. No extra logic is synthesised.

Test Plan:
1. WIDTH=32, DIGITS=10, SIGNED=1; reset, then start with binary=0 → done pulse 33 cycles after the start edge; bcd=40'h0000000000, negative=0, overflow=0; blank=10'h3FE with BCD_LZB_EN.
2. binary=32'd1234567890 → bcd=40'h1234567890, negative=0, overflow=0, busy high for exactly 32 cycles; blank=0 with BCD_LZB_EN.
3. binary=32'hFFFFFFFF with SIGNED=1 → bcd=40'h0000000001, negative=1. Same input with SIGNED=0 → bcd=40'h4294967295, negative=0.
4. binary=32'h80000000, SIGNED=1 → bcd=40'h2147483648, negative=1, overflow=0.
5. WIDTH=16, DIGITS=3, SIGNED=0:
   - binary=999 → bcd=12'h999, overflow=0.
   - binary=1000 → overflow=1.
   - binary=65535 → overflow=1.
6. Handshake and reset:
   - Pulse start again during SHIFT with a new value → ignored; result matches the first value.
   - Drop rst_n for one cycle at cycle 10 of a conversion → busy=0, no done pulse, bcd=0.
   - A new start after release converts correctly.
